// File: rtl/pcm_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pcm_frame_rx                                               |
// | Description : Receive-side PCM deframer. Hunts for and tracks an 8-bit   |
// |               frame-alignment word in the serial bit stream and          |
// |               deserializes the codewords that follow it. When the macro  |
// |               PCM_RX_EXPAND_EN is defined, each segmented codeword is    |
// |               expanded to an 8-bit sign-magnitude linear sample;         |
// |               otherwise the raw codeword is delivered.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pcm_frame_rx #(
    parameter logic [7:0] SYNC_WORD = 8'h1B,
    parameter int         N_WORDS   = 8,
    parameter int         MISS_MAX  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] sample_out,
    output logic       sample_valid,
    output logic [3:0] slot,
    output logic       locked,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [3:0] c_last_word = 4'(N_WORDS - 1);
    localparam logic [2:0] c_miss_max  = 3'(MISS_MAX);

    state_t     r_state;
    logic [7:0] r_sr;
    logic [3:0] r_fill;       // bits seen since reset, saturates at 8
    logic [2:0] r_bit_cnt;
    logic [3:0] r_word_cnt;
    logic [2:0] r_miss_cnt;

    logic [7:0] w_sr_next;
    logic [7:0] w_sample;
    logic [2:0] w_miss_inc;
    logic       w_fill_ok;
    logic       w_sync_hit;

`ifdef PCM_RX_EXPAND_EN
    // Segmented expansion: seg 0 is linear with a half-step offset, higher
    // segments carry an implied leading one plus a half-step rounding term.
    function automatic logic [7:0] f_expand(input logic [7:0] c);
        logic [2:0]  seg;
        logic [11:0] man;
        logic [11:0] mag;
        seg = c[6:4];
        man = {8'd0, c[3:0]};
        if (seg == 3'd0) begin
            mag = (man << 1) + 12'd1;
        end else begin
            mag = (12'd16 << seg) + (man << seg) + (12'd1 << (seg - 3'd1));
        end
        return {c[7], mag[11:5]};
    endfunction

    assign w_sample = f_expand(w_sr_next);
`else
    assign w_sample = w_sr_next;
`endif

    assign w_sr_next  = {r_sr[6:0], bit_in};
    assign w_miss_inc = r_miss_cnt + 3'd1;
    // The strobe being taken now is at least the 8th since reset.
    assign w_fill_ok  = (r_fill >= 4'd7);
    assign w_sync_hit = (w_sr_next == SYNC_WORD);

    // Framing FSM: shift register, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_sr         <= 8'd0;
            r_fill       <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_word_cnt   <= 4'd0;
            r_miss_cnt   <= 3'd0;
            sample_out   <= 8'd0;
            sample_valid <= 1'b0;
            slot         <= 4'd0;
            locked       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (bit_valid) begin
                r_sr <= w_sr_next;
                if (r_fill != 4'd8) begin
                    r_fill <= r_fill + 4'd1;
                end
                case (r_state)
                    ST_HUNT: begin
                        if (w_fill_ok && w_sync_hit) begin
                            r_state    <= ST_DATA;
                            r_bit_cnt  <= 3'd0;
                            r_word_cnt <= 4'd0;
                            r_miss_cnt <= 3'd0;
                            locked     <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            sample_out   <= w_sample;
                            slot         <= r_word_cnt;
                            sample_valid <= 1'b1;
                            if (r_word_cnt == c_last_word) begin
                                r_word_cnt <= 4'd0;
                                r_state    <= ST_CHECK;
                            end else begin
                                r_word_cnt <= r_word_cnt + 4'd1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_sync_hit) begin
                                r_miss_cnt <= 3'd0;
                                r_state    <= ST_DATA;
                            end else begin
                                frame_err  <= 1'b1;
                                r_miss_cnt <= w_miss_inc;
                                if (w_miss_inc == c_miss_max) begin
                                    // Lost alignment; sr is kept so hunting
                                    // can match on the very next strobe.
                                    r_state <= ST_HUNT;
                                    locked  <= 1'b0;
                                end else begin
                                    r_state <= ST_DATA;
                                end
                            end
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
